axil_arbiter_rd: RTL and testbench

Per-slave read-channel arbiter for the AXI-Lite interconnect.
- Chooses one of NUMBER_MASTER requesting masters by round-robin and produces the one-hot grant_rd vector.
- The downstream read crossbar stage uses grant_rd to steer AR and R signals to this slave.
- Holds a grant for one full read transaction: AR handshake, then R handshake.
- Exactly one outstanding read per slave.

---
 rtl/axil_pkg.sv | 19 +
 rtl/axil_rr_select.sv | 63 ++++++
 rtl/axil_arbiter_rd.sv | 133 +++++++++++++
 tb/tb_axil_arbiter_rd.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// -----------------------------------------------------------------------------
// axil_pkg
// Shared parameters and types for the AXI-Lite interconnect arbiters.
//   NUMBER_MASTER    : number of masters on the interconnect (>= 2)
//   MASTER_IDX_WIDTH : width of a master index / round-robin pointer
//   arb_state_t      : transaction FSM states shared by read and write arbiters
// -----------------------------------------------------------------------------
package axil_pkg;

   localparam int NUMBER_MASTER    = 4;
   localparam int MASTER_IDX_WIDTH = $clog2(NUMBER_MASTER);

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_ADDR = 2'd1,
      ARB_DATA = 2'd2
   } arb_state_t;

endpackage : axil_pkg

// File: rtl/axil_rr_select.sv
// -----------------------------------------------------------------------------
// axil_rr_select
// Combinational round-robin selector. Starting at index ptr and searching
// upward modulo NUMBER_MASTER, picks the first asserted request bit.
// Ports:
//   req        in  [NUMBER_MASTER-1:0]    request vector
//   ptr        in  [MASTER_IDX_WIDTH-1:0] highest-priority index
//   winner     out [NUMBER_MASTER-1:0]    one-hot winner (zero if no request)
//   winner_idx out [MASTER_IDX_WIDTH-1:0] binary winner index (zero if none)
//   any_req    out                        at least one request present
// -----------------------------------------------------------------------------
module axil_rr_select
   import axil_pkg::*;
(
   input  logic [NUMBER_MASTER-1:0]    req,
   input  logic [MASTER_IDX_WIDTH-1:0] ptr,
   output logic [NUMBER_MASTER-1:0]    winner,
   output logic [MASTER_IDX_WIDTH-1:0] winner_idx,
   output logic                        any_req
);

   localparam int SUM_WIDTH = MASTER_IDX_WIDTH + 1;

   logic [SUM_WIDTH-1:0]        cand_s;
   logic [MASTER_IDX_WIDTH-1:0] idx_s;
   logic                        found_s;

   // Rotating priority search: candidate index is (ptr + i) mod NUMBER_MASTER.
   // The sum fits in SUM_WIDTH bits since ptr and i are both below NUMBER_MASTER.
   always_comb begin
      cand_s  = '0;
      idx_s   = '0;
      found_s = 1'b0;
      for (int i = 0; i < NUMBER_MASTER; i++) begin
         cand_s = {1'b0, ptr} + SUM_WIDTH'(i);
         if (cand_s >= SUM_WIDTH'(NUMBER_MASTER)) begin
            cand_s = cand_s - SUM_WIDTH'(NUMBER_MASTER);
         end else begin
            cand_s = cand_s;
         end
         if (!found_s && req[cand_s[MASTER_IDX_WIDTH-1:0]]) begin
            found_s = 1'b1;
            idx_s   = cand_s[MASTER_IDX_WIDTH-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

   // Decode the selected index into the one-hot winner vector.
   always_comb begin
      winner = '0;
      if (found_s) begin
         winner[idx_s] = 1'b1;
      end else begin
         winner = '0;
      end
   end

   assign winner_idx = idx_s;
   assign any_req    = found_s;

endmodule : axil_rr_select

// File: rtl/axil_arbiter_rd.sv
// -----------------------------------------------------------------------------
// axil_arbiter_rd
// Per-slave read-channel arbiter. Grants one requesting master (round-robin)
// for a complete read transaction: AR handshake followed by R handshake.
// Only one read is outstanding per slave; at least one idle cycle separates
// consecutive grants.
// Ports:
//   aclk            in   clock, rising edge
//   aresetn         in   synchronous active-low reset
//   req_rd          in   [NUMBER_MASTER-1:0] decoded per-master read requests
//   s_axil_arvalid  in   muxed ARVALID at the slave
//   s_axil_arready  in   slave ARREADY
//   s_axil_rvalid   in   slave RVALID
//   s_axil_rready   in   muxed RREADY at the slave
//   grant_rd        out  [NUMBER_MASTER-1:0] registered one-hot grant, 0 idle
//   grant_idx       out  [MASTER_IDX_WIDTH-1:0] registered grant index, 0 idle
//   busy_rd         out  high while a transaction owns the slave
// -----------------------------------------------------------------------------
module axil_arbiter_rd
   import axil_pkg::*;
(
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [NUMBER_MASTER-1:0]    req_rd,
   input  logic                        s_axil_arvalid,
   input  logic                        s_axil_arready,
   input  logic                        s_axil_rvalid,
   input  logic                        s_axil_rready,
   output logic [NUMBER_MASTER-1:0]    grant_rd,
   output logic [MASTER_IDX_WIDTH-1:0] grant_idx,
   output logic                        busy_rd
);

   arb_state_t                  state_r;
   arb_state_t                  state_nxt_s;
   logic [NUMBER_MASTER-1:0]    grant_r;
   logic [NUMBER_MASTER-1:0]    grant_nxt_s;
   logic [MASTER_IDX_WIDTH-1:0] idx_r;
   logic [MASTER_IDX_WIDTH-1:0] idx_nxt_s;
   logic                        busy_r;
   logic                        busy_nxt_s;
   logic [MASTER_IDX_WIDTH-1:0] ptr_r;
   logic [MASTER_IDX_WIDTH-1:0] ptr_nxt_s;

   logic [NUMBER_MASTER-1:0]    winner_s;
   logic [MASTER_IDX_WIDTH-1:0] winner_idx_s;
   logic                        any_req_s;

   axil_rr_select u_rr_select (
      .req        (req_rd),
      .ptr        (ptr_r),
      .winner     (winner_s),
      .winner_idx (winner_idx_s),
      .any_req    (any_req_s)
   );

   // Next-state and next-output logic. Requests are only looked at in IDLE,
   // so a master withdrawing its request mid-transaction does not drop the grant.
   always_comb begin
      state_nxt_s = state_r;
      grant_nxt_s = grant_r;
      idx_nxt_s   = idx_r;
      busy_nxt_s  = busy_r;
      ptr_nxt_s   = ptr_r;
      case (state_r)
         ARB_IDLE: begin
            if (any_req_s) begin
               state_nxt_s = ARB_ADDR;
               grant_nxt_s = winner_s;
               idx_nxt_s   = winner_idx_s;
               busy_nxt_s  = 1'b1;
            end else begin
               state_nxt_s = ARB_IDLE;
               grant_nxt_s = '0;
               idx_nxt_s   = '0;
               busy_nxt_s  = 1'b0;
            end
         end
         ARB_ADDR: begin
            if (s_axil_arvalid && s_axil_arready) begin
               state_nxt_s = ARB_DATA;
            end else begin
               state_nxt_s = ARB_ADDR;
            end
         end
         ARB_DATA: begin
            if (s_axil_rvalid && s_axil_rready) begin
               state_nxt_s = ARB_IDLE;
               grant_nxt_s = '0;
               idx_nxt_s   = '0;
               busy_nxt_s  = 1'b0;
               // Previous winner becomes lowest priority.
               if (idx_r == MASTER_IDX_WIDTH'(NUMBER_MASTER - 1)) begin
                  ptr_nxt_s = '0;
               end else begin
                  ptr_nxt_s = idx_r + MASTER_IDX_WIDTH'(1);
               end
            end else begin
               state_nxt_s = ARB_DATA;
            end
         end
         default: begin
            state_nxt_s = ARB_IDLE;
            grant_nxt_s = '0;
            idx_nxt_s   = '0;
            busy_nxt_s  = 1'b0;
            ptr_nxt_s   = '0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_r <= ARB_IDLE;
         grant_r <= '0;
         idx_r   <= '0;
         busy_r  <= 1'b0;
         ptr_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         grant_r <= grant_nxt_s;
         idx_r   <= idx_nxt_s;
         busy_r  <= busy_nxt_s;
         ptr_r   <= ptr_nxt_s;
      end
   end

   assign grant_rd  = grant_r;
   assign grant_idx = idx_r;
   assign busy_rd   = busy_r;

endmodule : axil_arbiter_rd

// File: tb/tb_axil_arbiter_rd.sv
// -----------------------------------------------------------------------------
// tb_axil_arbiter_rd
// Self-checking bench for axil_arbiter_rd (NUMBER_MASTER = 4). Each expected
// grant is queued when requests are driven; a monitor pops and compares it
// when the DUT raises a new grant. Inputs change and outputs are sampled on
// the falling clock edge.
// -----------------------------------------------------------------------------
module tb_axil_arbiter_rd;
   import axil_pkg::*;

   logic                        aclk;
   logic                        aresetn;
   logic [NUMBER_MASTER-1:0]    req_rd;
   logic                        s_axil_arvalid;
   logic                        s_axil_arready;
   logic                        s_axil_rvalid;
   logic                        s_axil_rready;
   logic [NUMBER_MASTER-1:0]    grant_rd;
   logic [MASTER_IDX_WIDTH-1:0] grant_idx;
   logic                        busy_rd;

   int         n_vec = 0;
   int         n_err = 0;
   logic [3:0] sb_q[$];
   logic [3:0] prev_grant = 4'b0000;

   axil_arbiter_rd dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .req_rd         (req_rd),
      .s_axil_arvalid (s_axil_arvalid),
      .s_axil_arready (s_axil_arready),
      .s_axil_rvalid  (s_axil_rvalid),
      .s_axil_rready  (s_axil_rready),
      .grant_rd       (grant_rd),
      .grant_idx      (grant_idx),
      .busy_rd        (busy_rd)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Compare one observed value with its expected value and count it.
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Binary index of the highest set bit, 0 for an all-zero vector.
   function automatic logic [1:0] enc4(input logic [3:0] v);
      logic [1:0] r;
      r = 2'd0;
      for (int k = 0; k < 4; k++) begin
         if (v[k]) r = 2'(k);
      end
      return r;
   endfunction

   // Monitor: pop scoreboard on each new grant, check output consistency every cycle.
   always @(negedge aclk) begin
      if (grant_rd != 4'b0000 && prev_grant == 4'b0000) begin
         if (sb_q.size() == 0) begin
            check_eq("unexpected_grant", 32'(grant_rd), 32'h0);
         end else begin
            check_eq("grant_order", 32'(grant_rd), 32'(sb_q.pop_front()));
         end
      end
      check_eq("idx_matches_grant", 32'(grant_idx), 32'(enc4(grant_rd)));
      check_eq("busy_matches_grant", 32'(busy_rd), 32'(|grant_rd));
      check_eq("grant_onehot0", 32'($onehot0(grant_rd)), 32'h1);
      prev_grant <= grant_rd;
   end

   // One full read transaction, entered and left at a falling edge in IDLE.
   task automatic txn(input logic [3:0] req, input logic [3:0] req_addr,
                      input logic [3:0] exp, input int ar_stall, input int r_stall);
      int waited;
      req_rd = req;
      sb_q.push_back(exp);
      waited = 0;
      do begin
         @(negedge aclk);
         waited++;
      end while (grant_rd == 4'b0000 && waited < 8);
      check_eq("req_to_grant_cycles", 32'(waited), 32'd1);
      req_rd = req_addr;
      for (int k = 0; k < ar_stall; k++) begin
         // RVALID/RREADY are asserted here to confirm they are ignored in ADDR.
         s_axil_arvalid = 1'b1; s_axil_arready = 1'b0;
         s_axil_rvalid  = 1'b1; s_axil_rready  = 1'b1;
         @(negedge aclk);
         check_eq("hold_addr", 32'(grant_rd), 32'(exp));
      end
      s_axil_arvalid = 1'b1; s_axil_arready = 1'b1;
      s_axil_rvalid  = 1'b0; s_axil_rready  = 1'b0;
      @(negedge aclk);
      s_axil_arvalid = 1'b0; s_axil_arready = 1'b0;
      check_eq("hold_data", 32'(grant_rd), 32'(exp));
      check_eq("busy_data", 32'(busy_rd), 32'd1);
      for (int k = 0; k < r_stall; k++) begin
         s_axil_rvalid = 1'b1; s_axil_rready = 1'b0;
         @(negedge aclk);
         check_eq("hold_r_backpressure", 32'(grant_rd), 32'(exp));
      end
      s_axil_rvalid = 1'b1; s_axil_rready = 1'b1;
      @(negedge aclk);
      s_axil_rvalid = 1'b0; s_axil_rready = 1'b0;
      check_eq("release_grant", 32'(grant_rd), 32'h0);
      check_eq("release_busy", 32'(busy_rd), 32'd0);
   endtask

   initial begin
      aresetn        = 1'b0;
      req_rd         = 4'b1111;
      s_axil_arvalid = 1'b0;
      s_axil_arready = 1'b0;
      s_axil_rvalid  = 1'b0;
      s_axil_rready  = 1'b0;

      // 1: reset held with all requests, then first grant one cycle after release
      for (int k = 0; k < 3; k++) begin
         @(negedge aclk);
         check_eq("reset_grant", 32'(grant_rd), 32'h0);
         check_eq("reset_busy", 32'(busy_rd), 32'd0);
         check_eq("reset_idx", 32'(grant_idx), 32'h0);
      end
      aresetn = 1'b1;
      txn(4'b1111, 4'b1111, 4'b0001, 0, 0);

      // 2: continuous requests rotate and wrap 3 -> 0
      txn(4'b1111, 4'b1111, 4'b0010, 0, 0);
      txn(4'b1111, 4'b1111, 4'b0100, 0, 0);
      txn(4'b1111, 4'b1111, 4'b1000, 0, 0);
      txn(4'b1111, 4'b1111, 4'b0001, 0, 0);

      // 3: R backpressure for 10 cycles on master 2, then master 3 next
      txn(4'b0100, 4'b1011, 4'b0100, 0, 10);
      txn(4'b1011, 4'b1011, 4'b1000, 0, 0);

      // 4: lone requester wins repeatedly; then pointer 2 wraps to master 0
      txn(4'b0010, 4'b0010, 4'b0010, 0, 0);
      txn(4'b0010, 4'b0010, 4'b0010, 0, 0);
      txn(4'b0010, 4'b0010, 4'b0010, 0, 0);
      txn(4'b0011, 4'b0011, 4'b0001, 0, 0);

      // 5: master 3 drops its request in ADDR; grant held through both handshakes
      txn(4'b1000, 4'b0111, 4'b1000, 2, 2);
      txn(4'b0111, 4'b0111, 4'b0001, 0, 0);

      // 6: reset while in DATA with grant 0100
      req_rd = 4'b0100;
      sb_q.push_back(4'b0100);
      @(negedge aclk);
      s_axil_arvalid = 1'b1; s_axil_arready = 1'b1;
      @(negedge aclk);
      s_axil_arvalid = 1'b0; s_axil_arready = 1'b0;
      check_eq("t6_data_grant", 32'(grant_rd), 32'h4);
      aresetn = 1'b0;
      req_rd  = 4'b0110;
      @(negedge aclk);
      check_eq("t6_abort_grant", 32'(grant_rd), 32'h0);
      check_eq("t6_abort_busy", 32'(busy_rd), 32'd0);
      check_eq("t6_abort_idx", 32'(grant_idx), 32'h0);
      aresetn = 1'b1;
      txn(4'b0110, 4'b0110, 4'b0010, 0, 0);

      // 7: pointer returns to 0 on reset (ptr=3 beforehand would pick master 3)
      txn(4'b0100, 4'b0100, 4'b0100, 0, 0);
      aresetn = 1'b0;
      req_rd  = 4'b1001;
      @(negedge aclk);
      check_eq("t7_reset_grant", 32'(grant_rd), 32'h0);
      aresetn = 1'b1;
      txn(4'b1001, 4'b1001, 4'b0001, 0, 0);

      // No requests: arbiter stays idle
      req_rd = 4'b0000;
      for (int k = 0; k < 3; k++) begin
         @(negedge aclk);
         check_eq("idle_no_req", 32'(grant_rd), 32'h0);
      end
      check_eq("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_axil_arbiter_rd
